// File: rtl/imem_arb_pkg.sv
// -----------------------------------------------------------------------------
// imem_arb_pkg
// Shared types and defaults for the instruction-memory arbiter.
//   owner_e      : which requester owns the SRAM in a given cycle
//   MAX_WAIT_DEF : default fetch starvation limit in cycles
//   FWAIT_W      : width of the fetch wait counter (holds limits 1..15)
// -----------------------------------------------------------------------------
package imem_arb_pkg;

    typedef enum logic {
        OWN_FETCH  = 1'b0,
        OWN_LOADER = 1'b1
    } owner_e;

    localparam int MAX_WAIT_DEF = 4;
    localparam int FWAIT_W      = 4;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way pick between the fetch port and the loader port.
// The owner history it consumes is registered in the parent.
// Ports:
//   f_req, l_req : same-cycle requests
//   force_f      : fetch has waited its limit and must win a tie
//   hold_l       : loader asked to keep the grant it held last cycle
//   last_owner   : winner of the most recent granted cycle
//   f_win, l_win : one-hot (or zero) pick
// -----------------------------------------------------------------------------
module rr_arb2
    import imem_arb_pkg::*;
(
    input  logic   f_req,
    input  logic   l_req,
    input  logic   force_f,
    input  logic   hold_l,
    input  owner_e last_owner,
    output logic   f_win,
    output logic   l_win
);

    always_comb begin
        f_win = 1'b0;
        l_win = 1'b0;
        if (f_req && l_req) begin
            if (force_f) begin
                f_win = 1'b1;
            end else if (hold_l) begin
                l_win = 1'b1;
            end else if (last_owner == OWN_LOADER) begin
                f_win = 1'b1;
            end else begin
                l_win = 1'b1;
            end
        end else begin
            f_win = f_req;
            l_win = l_req;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
// Shares one single-port instruction SRAM between the core fetch port and a
// loader port. Grants are combinational; read data returns one cycle after
// the grant on the port that issued the read. One access per cycle.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   f_req, f_addr                      : fetch read request
//   f_gnt, f_rvalid, f_rdata           : fetch grant and read return
//   l_req, l_we, l_lock, l_addr, l_wdata : loader request (read/write, lock)
//   l_gnt, l_rvalid, l_rdata           : loader grant and read return
//   instr_sram_en/we/addr/wdata        : SRAM drive
//   instr                              : SRAM read data (1-cycle latency)
// -----------------------------------------------------------------------------
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,

    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,

    output logic              instr_sram_en,
    output logic              instr_sram_we,
    output logic [ADDR_W-1:0] instr_sram_addr,
    output logic [DATA_W-1:0] instr_sram_wdata,
    input  logic [DATA_W-1:0] instr
);

    localparam logic [FWAIT_W-1:0] WAIT_LIM = FWAIT_W'(MAX_WAIT);

    logic [FWAIT_W-1:0] fwait_p1;
    owner_e             last_owner_p1;
    logic               l_held_p1;
    logic               pend_p1;
    owner_e             rd_owner_p1;

    logic               f_win;
    logic               l_win;

    // The lock only extends a loader tenure that was live in the previous
    // cycle; after reset or an idle gap the tie falls back to round-robin,
    // which with last_owner reset to LOADER hands fetch the first tie.
    rr_arb2 u_pick (
        .f_req      (f_req),
        .l_req      (l_req),
        .force_f    (fwait_p1 == WAIT_LIM),
        .hold_l     (l_lock && l_held_p1),
        .last_owner (last_owner_p1),
        .f_win      (f_win),
        .l_win      (l_win)
    );

    // Grants are forced low while reset is held so every output is quiet.
    assign f_gnt = rst_n & f_win;
    assign l_gnt = rst_n & l_win;

    // Stage 0: SRAM drive from the winner
    always_comb begin
        instr_sram_en    = 1'b0;
        instr_sram_we    = 1'b0;
        instr_sram_addr  = '0;
        instr_sram_wdata = '0;
        if (f_gnt) begin
            instr_sram_en   = 1'b1;
            instr_sram_addr = f_addr;
        end else if (l_gnt) begin
            instr_sram_en    = 1'b1;
            instr_sram_we    = l_we;
            instr_sram_addr  = l_addr;
            instr_sram_wdata = l_wdata;
        end
    end

    // Stage 0 -> 1: owner history, starvation counter, read tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwait_p1      <= '0;
            last_owner_p1 <= OWN_LOADER;
            l_held_p1     <= 1'b0;
            pend_p1       <= 1'b0;
            rd_owner_p1   <= OWN_FETCH;
        end else begin
            if (f_gnt) begin
                last_owner_p1 <= OWN_FETCH;
            end else if (l_gnt) begin
                last_owner_p1 <= OWN_LOADER;
            end
            l_held_p1 <= l_gnt;

            if (!f_req || f_gnt) begin
                fwait_p1 <= '0;
            end else if (fwait_p1 != WAIT_LIM) begin
                fwait_p1 <= fwait_p1 + 1'b1;
            end

            // Writes retire at grant; only reads leave a response pending.
            pend_p1 <= f_gnt || (l_gnt && !l_we);
            if (f_gnt) begin
                rd_owner_p1 <= OWN_FETCH;
            end else if (l_gnt) begin
                rd_owner_p1 <= OWN_LOADER;
            end
        end
    end

    // Stage 1: route SRAM data to the port that issued the read
    assign f_rvalid = pend_p1 && (rd_owner_p1 == OWN_FETCH);
    assign l_rvalid = pend_p1 && (rd_owner_p1 == OWN_LOADER);
    assign f_rdata  = f_rvalid ? instr : '0;
    assign l_rdata  = l_rvalid ? instr : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int GN = 0;  // no grant expected
    localparam int GF = 1;  // fetch grant expected
    localparam int GL = 2;  // loader grant expected

    logic          clk = 1'b0;
    logic          rst_n;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt, f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          l_req, l_we, l_lock;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_gnt, l_rvalid;
    logic [DW-1:0] l_rdata;
    logic          instr_sram_en, instr_sram_we;
    logic [AW-1:0] instr_sram_addr;
    logic [DW-1:0] instr_sram_wdata;
    logic [DW-1:0] instr = '0;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] sram[logic [31:0]];

    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .f_req            (f_req),
        .f_addr           (f_addr),
        .f_gnt            (f_gnt),
        .f_rvalid         (f_rvalid),
        .f_rdata          (f_rdata),
        .l_req            (l_req),
        .l_we             (l_we),
        .l_lock           (l_lock),
        .l_addr           (l_addr),
        .l_wdata          (l_wdata),
        .l_gnt            (l_gnt),
        .l_rvalid         (l_rvalid),
        .l_rdata          (l_rdata),
        .instr_sram_en    (instr_sram_en),
        .instr_sram_we    (instr_sram_we),
        .instr_sram_addr  (instr_sram_addr),
        .instr_sram_wdata (instr_sram_wdata),
        .instr            (instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Behavioural SRAM driven by the DUT's SRAM outputs.
    always @(posedge clk) begin
        if (instr_sram_en) begin
            if (instr_sram_we) sram[instr_sram_addr] = instr_sram_wdata;
            else instr <= sram.exists(instr_sram_addr) ? sram[instr_sram_addr] : seed(instr_sram_addr);
        end
    end

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ".f_gnt"},    f_gnt,            0);
        chk({tag, ".l_gnt"},    l_gnt,            0);
        chk({tag, ".f_rvalid"}, f_rvalid,         0);
        chk({tag, ".l_rvalid"}, l_rvalid,         0);
        chk({tag, ".f_rdata"},  f_rdata,          0);
        chk({tag, ".l_rdata"},  l_rdata,          0);
        chk({tag, ".en"},       instr_sram_en,    0);
        chk({tag, ".we"},       instr_sram_we,    0);
        chk({tag, ".addr"},     instr_sram_addr,  0);
        chk({tag, ".wdata"},    instr_sram_wdata, 0);
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lwe,
                         input logic llock, input logic [31:0] la, input logic [31:0] lwd);
        f_req = fr; f_addr = fa;
        l_req = lr; l_we = lwe; l_lock = llock; l_addr = la; l_wdata = lwd;
    endtask

    // One bus cycle: drive after the edge, check at the falling edge,
    // retire the response expected from last cycle, queue this cycle's.
    task automatic cyc(input logic fr, input logic [31:0] fa, input logic lr, input logic lwe,
                       input logic llock, input logic [31:0] la, input logic [31:0] lwd,
                       input int eg, input string tag);
        rsp_t r;
        rsp_t nr;
        @(posedge clk); #1;
        drive(fr, fa, lr, lwe, llock, la, lwd);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
            r.port = GN; r.data = '0;
        end else begin
            r = sb.pop_front();
        end
        chk({tag, ".f_rvalid"}, f_rvalid, (r.port == GF));
        chk({tag, ".l_rvalid"}, l_rvalid, (r.port == GL));
        chk({tag, ".f_rdata"},  f_rdata,  (r.port == GF) ? r.data : 32'h0);
        chk({tag, ".l_rdata"},  l_rdata,  (r.port == GL) ? r.data : 32'h0);
        chk({tag, ".f_gnt"}, f_gnt, (eg == GF));
        chk({tag, ".l_gnt"}, l_gnt, (eg == GL));
        chk({tag, ".en"},    instr_sram_en, (eg != GN));
        chk({tag, ".we"},    instr_sram_we, (eg == GL) && lwe);
        chk({tag, ".addr"},  instr_sram_addr, (eg == GF) ? fa : (eg == GL) ? la : 32'h0);
        chk({tag, ".wdata"}, instr_sram_wdata, (eg == GL) ? lwd : 32'h0);
        nr.port = GN; nr.data = '0;
        if (eg == GF) begin
            nr.port = GF; nr.data = ref_rd(fa);
        end else if (eg == GL && !lwe) begin
            nr.port = GL; nr.data = ref_rd(la);
        end else if (eg == GL && lwe) begin
            ref_mem[la] = lwd;
        end
        sb.push_back(nr);
    endtask

    task automatic idle(input string tag);
        cyc(0, 0, 0, 0, 0, 0, 0, GN, tag);
    endtask

    // Reset with both requests active; pending reads must be discarded.
    task automatic reset_pulse(input string tag);
        rsp_t z;
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1, 32'h44, 1, 0, 1, 32'h88, 32'h0);
        #2;
        check_quiet(tag);
        @(posedge clk); #1;
        check_quiet({tag, "_hold"});
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        sb.delete();
        z.port = GN; z.data = '0;
        sb.push_back(z);
    endtask

    string fl_lock  = "FLLLLFLLLLF";
    string fl_drop  = "FLLLLLLLLF";

    initial begin
        rsp_t z;
        rst_n = 1'b0;
        drive(1, 32'h10, 1, 0, 0, 32'h20, 32'h0);
        #3;
        check_quiet("reset");
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        z.port = GN; z.data = '0;
        sb.push_back(z);

        // Single fetch read, then loader write / read-back
        cyc(1, 32'h1, 0, 0, 0, 0, 0, GF, "fetch1");
        idle("fetch1_rsp");
        cyc(0, 0, 1, 1, 0, 32'h5, 32'hDEADBEEF, GL, "lwrite");
        idle("lwrite_norsp");
        cyc(0, 0, 1, 0, 0, 32'h5, 0, GL, "lread");
        idle("lread_rsp");

        // Both requesting, no lock: strict alternation from reset
        reset_pulse("rst_a");
        for (int i = 0; i < 6; i++)
            cyc(1, 32'h100 + i, 1, 0, 0, 32'h200 + i, 0, (i % 2 == 0) ? GF : GL, $sformatf("alt%0d", i));
        idle("alt_tail");

        // Both requesting with lock: F, four L, forced F, repeat
        reset_pulse("rst_b");
        for (int i = 0; i < fl_lock.len(); i++)
            cyc(1, 32'h300 + i, 1, 0, 1, 32'h400 + i, 0,
                (fl_lock[i] == "F") ? GF : GL, $sformatf("lock%0d", i));
        idle("lock_tail");

        // Fetch drops its request mid-wait: starvation count restarts
        reset_pulse("rst_c");
        for (int i = 0; i < fl_drop.len(); i++)
            cyc((i == 4) ? 1'b0 : 1'b1, 32'h500 + i, 1, 0, 1, 32'h600 + i, 0,
                (fl_drop[i] == "F") ? GF : GL, $sformatf("drop%0d", i));
        idle("drop_tail");

        // Reset in the cycle after a fetch grant discards the read
        cyc(1, 32'h77, 0, 0, 0, 0, 0, GF, "pre_rst");
        reset_pulse("rst_d");
        idle("post_rst");
        cyc(1, 32'h78, 0, 0, 0, 0, 0, GF, "post_rst_f");
        idle("post_rst_rsp");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
